bcd_seq_converter: RTL
======================

BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter: DONE_LEVEL, default 0; 0 makes done a 1-cycle pulse, 1 holds done high until the next accepted start.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request conversion of bin; sampled on rising clk.
REQ-006 bin  input  8  unsigned binary value, 0..255.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  conversion-complete indicator, per DONE_LEVEL.
REQ-009 ones  output  4  BCD units digit, 0..9.
REQ-010 tens  output  4  BCD tens digit, 0..9.
REQ-011 hundreds  output  2  BCD hundreds digit, 0..2.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and FINISH.
REQ-013 IDLE + start=1: capture bin into an 8-bit shift register, clear the 10-bit BCD scratch, clear the 3-bit iteration counter, go to SHIFT.
REQ-014 Each SHIFT cycle (shift-add-3): add 3 to every scratch BCD nibble >=5, then shift {scratch, shiftreg} left 1, then increment the counter.
REQ-015 After the 8th SHIFT cycle (counter wraps 7->0), go to FINISH.
REQ-016 FINISH: load ones/tens/hundreds from scratch, assert done, return to IDLE next cycle.
REQ-017 Latency: start sampled at edge N -> results and done visible after edge N+9.
REQ-018 busy SHALL be 1 in SHIFT and FINISH, and 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored and not queued; bin changes during conversion SHALL have no effect.
REQ-020 start in the cycle done pulses (back in IDLE) SHALL be accepted normally; back-to-back throughput is one conversion per 10 cycles.
REQ-021 ones/tens/hundreds SHALL hold the last completed result until the next FINISH.
REQ-022 Results SHALL equal bin mod 10, (bin/10) mod 10 and bin/100 for all 256 inputs.
REQ-023 DONE_LEVEL=1: done set in FINISH, cleared when the next start is accepted.

Reset
REQ-024 reset=1 SHALL, at the next edge and from any state (including mid-SHIFT), force IDLE, busy=0, done=0, ones=tens=0, hundreds=0, counter=0 and scratch=0.
REQ-025 reset SHALL take priority over start in the same cycle.

Configuration
REQ-026 Macro BCD_LEADING_BLANK_EN defined: add outputs blank_hundreds (1 bit) and blank_tens (1 bit), registered and updated in FINISH.
REQ-027 With the macro: blank_hundreds=1 iff hundreds==0; blank_tens=1 iff hundreds==0 and tens==0; both reset to 1.
REQ-028 Without the macro: the blank ports and their logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE/SHIFT/FINISH), BIN_W=8, BCD_DIGITS=3 and the add-3 threshold constant 5.
REQ-030 The per-nibble conditional add-3 SHALL be a sub-module bcd_nibble_adj (4-bit in, 4-bit out, combinational), instantiated once per scratch digit.
REQ-031 Outputs SHALL be registered; no combinational path from start or bin to any output.

Verification
REQ-032 reset, then start with bin=0 -> done after 9 edges; ones=0, tens=0, hundreds=0.
REQ-033 start with bin=255 -> busy=1 for 9 cycles; ones=5, tens=5, hundreds=2; DONE_LEVEL=0 gives a single-cycle done pulse.
REQ-034 start with bin=99, then start with bin=200 on the 3rd busy cycle -> result 9/9/0, no second conversion, busy falls after 9 cycles.
REQ-035 start with bin=137, then reset on the 4th SHIFT cycle -> next cycle IDLE with all outputs 0; a new start with bin=42 then gives 2/4/0.
REQ-036 Exhaustive sweep of bin 0..255 back-to-back (start on each done) -> every result matches the reference arithmetic; DONE_LEVEL=1 keeps done high between conversions.
REQ-037 With BCD_LEADING_BLANK_EN, bin=7 -> blank_hundreds=1, blank_tens=1; bin=105 -> blank_hundreds=0, blank_tens=0.

Source files
------------

// File: rtl/bcd_seq_converter_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bcd_seq_converter_pkg;

  localparam int unsigned BIN_W      = 8;
  localparam int unsigned BCD_DIGITS = 3;
  // Top digit only ever needs 2 bits for an 8-bit input (max 2).
  localparam int unsigned SCRATCH_W  = 4 * (BCD_DIGITS - 1) + 2;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFinish = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_nibble_adj
  import bcd_seq_converter_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADD3_THRESHOLD) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-add-3 binary-to-BCD converter, one result per 10 cycles.
// Optional leading-zero blank flags are enabled by defining BCD_LEADING_BLANK_EN.
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int unsigned DONE_LEVEL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [1:0]       hundreds
`ifdef BCD_LEADING_BLANK_EN
  ,
  output logic             blank_hundreds,
  output logic             blank_tens
`endif
);

  state_e               state_q, state_d;
  logic [BIN_W-1:0]     shreg_q, shreg_d;
  logic [SCRATCH_W-1:0] scratch_q, scratch_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [3:0]           ones_q, ones_d;
  logic [3:0]           tens_q, tens_d;
  logic [1:0]           hundreds_q, hundreds_d;

  logic [4*BCD_DIGITS-1:0] scratch_pad;
  logic [4*BCD_DIGITS-1:0] adj;
  logic [2:0]              unused_adj_hi;

  // Pad the 2-bit top digit so every digit shares the same 4-bit adjuster.
  assign scratch_pad   = {{(4*BCD_DIGITS-SCRATCH_W){1'b0}}, scratch_q};
  assign unused_adj_hi = adj[4*BCD_DIGITS-1:SCRATCH_W-1];

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din  (scratch_pad[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

`ifdef BCD_LEADING_BLANK_EN
  logic blank_hundreds_q, blank_hundreds_d;
  logic blank_tens_q, blank_tens_d;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    done_d     = (DONE_LEVEL != 0) ? done_q : 1'b0;
`ifdef BCD_LEADING_BLANK_EN
    blank_hundreds_d = blank_hundreds_q;
    blank_tens_d     = blank_tens_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = 3'd0;
          state_d   = StShift;
          if (DONE_LEVEL != 0) begin
            done_d = 1'b0;
          end
        end
      end
      StShift: begin
        {scratch_d, shreg_d} = {adj[SCRATCH_W-2:0], shreg_q, 1'b0};
        cnt_d                = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        ones_d     = scratch_q[3:0];
        tens_d     = scratch_q[7:4];
        hundreds_d = scratch_q[9:8];
        done_d     = 1'b1;
        state_d    = StIdle;
`ifdef BCD_LEADING_BLANK_EN
        blank_hundreds_d = (scratch_q[9:8] == 2'd0);
        blank_tens_d     = (scratch_q[9:8] == 2'd0) && (scratch_q[7:4] == 4'd0);
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
    end
  end

`ifdef BCD_LEADING_BLANK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_hundreds_q <= 1'b1;
      blank_tens_q     <= 1'b1;
    end else begin
      blank_hundreds_q <= blank_hundreds_d;
      blank_tens_q     <= blank_tens_d;
    end
  end

  assign blank_hundreds = blank_hundreds_q;
  assign blank_tens     = blank_tens_q;
`endif

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;

endmodule
